// File: rtl/microgreen_cam_pkg.sv
// Shared types and constants for the OV7670 capture front end: FSM states,
// RGB565 field widths, sensor geometry and the packed pixel FIFO entry.
package microgreen_cam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_FRAME  = 2'd2
   } cap_state_t;

   localparam int R_W      = 5;
   localparam int G_W      = 6;
   localparam int B_W      = 5;
   localparam int RGB_W    = R_W + G_W + B_W;
   localparam int SENSOR_W = 640;
   localparam int SENSOR_H = 480;
   localparam int COL_W    = 10;
   localparam int ROW_W    = 9;

   typedef struct packed {
      logic [RGB_W-1:0] rgb;
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic             sof;
      logic             sol;
   } pix_entry_t;

   localparam int ENTRY_W = $bits(pix_entry_t);

   function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] c);
      return (c == COL_W'(SENSOR_W - 1)) ? '0 : c + COL_W'(1);
   endfunction

   function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
      return (r == ROW_W'(SENSOR_H - 1)) ? '0 : r + ROW_W'(1);
   endfunction

endpackage

// File: rtl/ov7670_pixel_capture_fifo.sv
// Synchronous pixel FIFO; a push while full is still accepted when a pop
// happens in the same cycle (the slot being vacated is overwritten).
module capture_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          w_wr_en;
   logic          w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);
   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 front end: synchronizes camera pins into clk, assembles RGB565 pixels
// with coordinates and queues them. Optional macro: CAPTURE_WINDOW_EN (crop).
//
// state  | meaning
// IDLE   | disabled or just reset; waiting for vsync high
// VBLANK | vertical blank; waiting for vsync to fall
// FRAME  | active frame; lines are captured
module ov7670_pixel_capture
   import microgreen_cam_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WIN_X0     = 0,
   parameter int WIN_X1     = 639,
   parameter int WIN_Y0     = 0,
   parameter int WIN_Y1     = 479
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        cam_pclk,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_d,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] pix_rgb,
   output logic [9:0]  pix_col,
   output logic [8:0]  pix_row,
   output logic        pix_sof,
   output logic        pix_sol,
   output logic        frame_done,
   output logic [7:0]  ovf_cnt,
   output logic [7:0]  line_err_cnt
);

   logic [2:0]       r_pclk_sync, r_href_sync, r_vs_sync;
   logic [7:0]       r_d_s1, r_d_s2, r_smp_d, r_hi;
   logic             r_smp_vld, r_eol, r_phase, r_push;
   logic             r_sof_pend, r_sol_pend, r_frame_done;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [7:0]       r_ovf, r_line_err;
   pix_entry_t       r_entry;
   cap_state_t       r_state, w_state_nxt;
   logic             w_pclk_rise, w_href_fall, w_vs, w_in_frame, w_in_win;
   logic             w_enter_frame, w_frame_end;
   logic             w_full, w_empty, w_pop, w_push_ok;
   logic [ENTRY_W-1:0] w_head_bits;
   pix_entry_t       w_head;

   assign w_pclk_rise = r_pclk_sync[1] && !r_pclk_sync[2];
   assign w_href_fall = !r_href_sync[1] && r_href_sync[2];
   assign w_vs        = r_vs_sync[2];
   assign w_in_frame  = (r_state == ST_FRAME) && ena;

`ifdef CAPTURE_WINDOW_EN
   localparam logic [COL_W-1:0] LP_X0 = COL_W'(WIN_X0);
   localparam logic [COL_W-1:0] LP_X1 = COL_W'(WIN_X1);
   localparam logic [ROW_W-1:0] LP_Y0 = ROW_W'(WIN_Y0);
   localparam logic [ROW_W-1:0] LP_Y1 = ROW_W'(WIN_Y1);
   assign w_in_win = (r_col >= LP_X0) && (r_col <= LP_X1) &&
                     (r_row >= LP_Y0) && (r_row <= LP_Y1);
`else
   assign w_in_win = 1'b1;
`endif

   // Stage-2 href/vsync/data taken at the PCLK edge form one coherent sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pclk_sync <= '0;
         r_href_sync <= '0;
         r_vs_sync   <= '0;
         r_d_s1      <= '0;
         r_d_s2      <= '0;
         r_smp_vld   <= 1'b0;
         r_smp_d     <= '0;
         r_eol       <= 1'b0;
      end else begin
         r_pclk_sync <= {r_pclk_sync[1:0], cam_pclk};
         r_href_sync <= {r_href_sync[1:0], cam_href};
         r_vs_sync   <= {r_vs_sync[1:0], cam_vsync};
         r_d_s1      <= cam_d;
         r_d_s2      <= r_d_s1;
         r_smp_vld   <= w_pclk_rise && r_href_sync[1] && !r_vs_sync[1];
         r_smp_d     <= r_d_s2;
         r_eol       <= w_href_fall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_vs)  w_state_nxt = ST_VBLANK;
         ST_VBLANK: if (!w_vs) w_state_nxt = ST_FRAME;
         ST_FRAME:  if (w_vs)  w_state_nxt = ST_VBLANK;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (!ena) w_state_nxt = ST_IDLE;
      w_enter_frame = (r_state == ST_VBLANK) && (w_state_nxt == ST_FRAME);
      w_frame_end   = (r_state == ST_FRAME) && (w_state_nxt == ST_VBLANK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= 1'b0;
         r_hi       <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_push     <= 1'b0;
         r_entry    <= '0;
         r_line_err <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_enter_frame) begin
            r_row   <= '0;
            r_col   <= '0;
            r_phase <= 1'b0;
         end else if (!w_in_frame) begin
            r_col   <= '0;
            r_phase <= 1'b0;
         end else if (r_smp_vld) begin
            if (!r_phase) begin
               r_hi    <= r_smp_d;
               r_phase <= 1'b1;
            end else begin
               r_phase <= 1'b0;
               r_push  <= w_in_win;
               r_entry <= '{rgb: {r_hi, r_smp_d}, col: r_col, row: r_row,
                            sof: r_sof_pend, sol: r_sol_pend};
               r_col   <= next_col(r_col);
            end
         end else if (r_eol) begin
            r_phase <= 1'b0;
            r_col   <= '0;
            r_row   <= next_row(r_row);
            if (r_phase && (r_line_err != 8'hFF)) r_line_err <= r_line_err + 8'd1;
         end
      end
   end

   // Flags are consumed only by a pixel the FIFO actually accepts; a new line start wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sof_pend   <= 1'b0;
         r_sol_pend   <= 1'b0;
         r_ovf        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         if (r_push && !w_push_ok && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
         if (w_enter_frame) begin
            r_sof_pend <= 1'b1;
            r_sol_pend <= 1'b1;
         end else begin
            if (w_push_ok && r_entry.sof) r_sof_pend <= 1'b0;
            if (w_push_ok && r_entry.sol) r_sol_pend <= 1'b0;
            if (w_in_frame && !r_smp_vld && r_eol) r_sol_pend <= 1'b1;
         end
      end
   end

   assign w_pop     = !w_empty && pix_ready;
   assign w_push_ok = r_push && (!w_full || w_pop);

   capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_push),
      .i_din   (r_entry),
      .i_pop   (w_pop),
      .o_dout  (w_head_bits),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head       = pix_entry_t'(w_head_bits);
   assign pix_valid    = !w_empty;
   assign pix_rgb      = w_head.rgb;
   assign pix_col      = w_head.col;
   assign pix_row      = w_head.row;
   assign pix_sof      = w_head.sof;
   assign pix_sol      = w_head.sol;
   assign frame_done   = r_frame_done;
   assign ovf_cnt      = r_ovf;
   assign line_err_cnt = r_line_err;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed/randomized bench for ov7670_pixel_capture against a frame-level
// reference model; honours CAPTURE_WINDOW_EN when the build defines it.
module tb_ov7670_pixel_capture;

   localparam int TB_DEPTH = 4;
   localparam int TB_WX0 = 2, TB_WX1 = 3, TB_WY0 = 1, TB_WY1 = 1;

   typedef struct packed {
      logic [15:0] rgb;
      logic [9:0]  col;
      logic [8:0]  row;
      logic        sof;
      logic        sol;
   } px_t;

   logic        clk = 1'b0;
   logic        rst_n, ena, cam_pclk, cam_vsync, cam_href, pix_ready;
   logic [7:0]  cam_d;
   logic        pix_valid, pix_sof, pix_sol, frame_done;
   logic [15:0] pix_rgb;
   logic [9:0]  pix_col;
   logic [8:0]  pix_row;
   logic [7:0]  ovf_cnt, line_err_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int fd_cnt = 0;
   int fd_exp = 0;

   px_t        exp_q[$];
   logic [7:0] line_b[$];
   int         m_row, m_cap, m_ovf, m_err;
   bit         m_sof, m_sol;

   always #20 clk = ~clk;

   ov7670_pixel_capture #(
      .FIFO_DEPTH (TB_DEPTH),
      .WIN_X0     (TB_WX0),
      .WIN_X1     (TB_WX1),
      .WIN_Y0     (TB_WY0),
      .WIN_Y1     (TB_WY1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .cam_pclk     (cam_pclk),
      .cam_vsync    (cam_vsync),
      .cam_href     (cam_href),
      .cam_d        (cam_d),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_rgb      (pix_rgb),
      .pix_col      (pix_col),
      .pix_row      (pix_row),
      .pix_sof      (pix_sof),
      .pix_sol      (pix_sol),
      .frame_done   (frame_done),
      .ovf_cnt      (ovf_cnt),
      .line_err_cnt (line_err_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      assert (got === expv) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
      end
   endtask

   function automatic bit in_win(input int col, input int row);
`ifdef CAPTURE_WINDOW_EN
      return (col >= TB_WX0) && (col <= TB_WX1) && (row >= TB_WY0) && (row <= TB_WY1);
`else
      return 1'b1;
`endif
   endfunction

   // Consumer side: every accepted pixel must be the next one the model predicts.
   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_pixel got=%0h exp=none",
                   {pix_rgb, pix_col, pix_row, pix_sof, pix_sol});
         end
         if (exp_q.size() > 0) chk("pixel", {pix_rgb, pix_col, pix_row, pix_sof, pix_sol}, exp_q.pop_front());
      end
   end

   initial begin
      #(40 * 60000);
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fill_pattern(input int n);
      line_b.delete();
      for (int i = 0; i < n; i++) line_b.push_back((i % 2 == 0) ? 8'hF8 : 8'h1F);
   endtask

   task automatic fill_random(input int n);
      line_b.delete();
      for (int i = 0; i < n; i++) line_b.push_back(8'($urandom));
   endtask

   task automatic model_line();
      int  npix;
      px_t p;
      npix  = line_b.size() / 2;
      m_sol = 1'b1;
      for (int k = 0; k < npix; k++) begin
         if (in_win(k, m_row)) begin
            if (m_cap > 0) begin
               p.rgb = {line_b[2*k], line_b[2*k+1]};
               p.col = 10'(k);
               p.row = 9'(m_row);
               p.sof = m_sof;
               p.sol = m_sol;
               exp_q.push_back(p);
               m_sof = 1'b0;
               m_sol = 1'b0;
               m_cap--;
            end else begin
               m_ovf++;
            end
         end
      end
      if (line_b.size() % 2 != 0) m_err++;
      m_row++;
   endtask

   task automatic byte_out(input logic [7:0] d, input bit lat);
      cam_pclk = 1'b0;
      cam_d    = d;
      cyc($urandom_range(2, 4));
      cam_pclk = 1'b1;
      if (lat) begin
         int at = 0;
         for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (pix_valid && at == 0) at = i;
         end
         chk("latency", at, 5);
      end
      cyc($urandom_range(2, 4));
   endtask

   task automatic send_line(input bit lat);
      cam_href = 1'b1;
      for (int i = 0; i < line_b.size(); i++) byte_out(line_b[i], lat && (i == 1));
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      cyc(6);
   endtask

   task automatic frame_begin();
      cam_vsync = 1'b1;
      cyc(8);
      cam_vsync = 1'b0;
      cyc(8);
      m_row = 0;
      m_sof = 1'b1;
   endtask

   task automatic frame_end(input bit chk_fd);
      cam_vsync = 1'b1;
      if (chk_fd) begin
         int at = 0;
         for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (frame_done && at == 0) at = i;
         end
         chk("frame_done_lat", at, 4);
         fd_exp++;
      end else begin
         cyc(8);
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0;
      cam_href = 1'b0; cam_d = 8'h00; pix_ready = 1'b0;
      m_row = 0; m_cap = 1000; m_ovf = 0; m_err = 0; m_sof = 1'b0; m_sol = 1'b0;
      cyc(4);
      chk("rst_valid", pix_valid, 0);
      chk("rst_rgb", pix_rgb, 0);
      chk("rst_col", pix_col, 0);
      chk("rst_row", pix_row, 0);
      chk("rst_sof", pix_sof, 0);
      chk("rst_sol", pix_sol, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", ovf_cnt, 0);
      chk("rst_lerr", line_err_cnt, 0);
      rst_n = 1'b1; ena = 1'b1; pix_ready = 1'b1;
      cyc(4);

      // Reset in the middle of a line, then the rest of the line: nothing may come out.
      fill_random(8);
      cam_href = 1'b1;
      for (int i = 0; i < 4; i++) byte_out(line_b[i], 1'b0);
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      for (int i = 4; i < 8; i++) byte_out(line_b[i], 1'b0);
      cam_pclk = 1'b0; cam_href = 1'b0;
      cyc(10);
      chk("no_push_before_frame", pix_valid, 0);

      // 4x8 frame of 0xF81F pixels.
      frame_begin();
      for (int l = 0; l < 4; l++) begin
         fill_pattern(16);
         model_line();
         send_line(1'b0);
      end
      frame_end(1'b1);
      wait_drain("drain_4x8");

      // Stalled consumer: a 10-pixel line into a 4-deep FIFO.
      pix_ready = 1'b0;
      m_cap = TB_DEPTH;
      frame_begin();
      fill_random(20);
      model_line();
`ifdef CAPTURE_WINDOW_EN
      send_line(1'b0);
`else
      send_line(1'b1);
`endif
      chk("ovf_cnt", ovf_cnt, 8'(m_ovf));
      if (exp_q.size() > 0) chk("head_held", {pix_rgb, pix_col, pix_row, pix_sof, pix_sol}, exp_q[0]);
      frame_end(1'b1);
      if (exp_q.size() > 0) chk("head_stable", {pix_rgb, pix_col, pix_row, pix_sof, pix_sol}, exp_q[0]);
      pix_ready = 1'b1;
      m_cap = 1000;
      wait_drain("drain_ovf");

      // Odd-length line followed by normal lines.
      frame_begin();
      fill_random(5);  model_line(); send_line(1'b0);
      fill_random(8);  model_line(); send_line(1'b0);
      fill_random(10); model_line(); send_line(1'b0);
      frame_end(1'b1);
      wait_drain("drain_odd");
      chk("line_err_cnt", line_err_cnt, 8'(m_err));

      // Enable dropped mid-frame: queued pixels drain, nothing new is pushed.
      pix_ready = 1'b0;
      m_cap = TB_DEPTH;
      frame_begin();
      fill_random(6);
      model_line();
      send_line(1'b0);
      ena = 1'b0;
      cyc(2);
      fill_random(8);
      send_line(1'b0);
      frame_end(1'b0);
      pix_ready = 1'b1;
      m_cap = 1000;
      wait_drain("drain_ena");
      cyc(10);
      chk("fd_after_ena_drop", fd_cnt, fd_exp);

      // Re-enable and capture one more randomized frame.
      ena = 1'b1;
      frame_begin();
      for (int l = 0; l < 3; l++) begin
         fill_random(2 * $urandom_range(3, 6));
         model_line();
         send_line(1'b0);
      end
      frame_end(1'b1);
      wait_drain("drain_final");
      cyc(4);
      chk("ovf_total", ovf_cnt, 8'(m_ovf));
      chk("lerr_total", line_err_cnt, 8'(m_err));
      chk("fd_total", fd_cnt, fd_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
